// File: rtl/pe_array_dispatch_cntl_pkg.sv
// Shared encodings for the PE-array command dispatcher: command types,
// controller states and the array's PE-count constant.
package pe_array_dispatch_cntl_pkg;

  localparam int PE_COUNT = 64;

  typedef enum logic [1:0] {
    CMD_UNICAST = 2'd0,
    CMD_BCAST   = 2'd1,
    CMD_SYNC    = 2'd2,
    CMD_RSVD    = 2'd3
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_BCAST     = 3'd2,
    ST_SYNC_WAIT = 3'd3,
    ST_SYNC_REL  = 3'd4
  } state_e;

endpackage

// File: rtl/pe_array_dispatch_cntl_fifo.sv
// Small synchronous command FIFO; pointers wrap naturally and an extra count
// bit distinguishes full from empty.
module dsp_cmd_fifo #(
  parameter int WIDTH = 72,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wdata,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rdata,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/pe_array_dispatch_cntl.sv
// Command dispatcher and barrier controller: buffers stack-bus commands and
// delivers them to one PE or all PEs, and sequences array-wide barriers.
module pe_array_dispatch_cntl
  import pe_array_dispatch_cntl_pkg::*;
#(
  parameter int NUM_PE     = PE_COUNT,
  parameter int PE_ID_W    = 6,
  parameter int DATA_W     = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_poweron,
  input  logic                stbd__dsp__valid,
  output logic                dsp__stbd__ready,
  input  logic [1:0]          stbd__dsp__type,
  input  logic [PE_ID_W-1:0]  stbd__dsp__peId,
  input  logic [DATA_W-1:0]   stbd__dsp__data,
  output logic [NUM_PE-1:0]   dsp__pe__valid,
  output logic [DATA_W-1:0]   dsp__pe__data,
  input  logic [NUM_PE-1:0]   pe__dsp__ready,
  input  logic [NUM_PE-1:0]   pe__sys__thisSynchronized,
  output logic                sys__pe__allSynchronized,
  output logic                dsp__sys__busy,
  output logic                dsp__sys__err
);
  localparam int CMD_W = 2 + PE_ID_W + DATA_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    cmd_type_e            typ;
    logic [PE_ID_W-1:0]   pe_id;
    logic [DATA_W-1:0]    data;
  } cmd_t;

  state_e            r_state;
  logic [NUM_PE-1:0] r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_allsync;
  logic              r_busy;
  logic              r_err;

  state_e            w_state_nxt;
  logic [NUM_PE-1:0] w_valid_nxt;
  logic [NUM_PE-1:0] w_left;
  logic              w_err_nxt;
  logic              w_load;
  logic              w_pop;
  logic              w_push;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [CMD_W-1:0]  w_head_bits;
  cmd_t              w_head;
  logic              w_bad_id;

  assign dsp__stbd__ready = ~w_full;
  assign w_push           = stbd__dsp__valid & ~w_full;
  assign w_head           = w_head_bits;
  assign w_bad_id         = (32'(w_head.pe_id) >= NUM_PE);

  dsp_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .i_push        (w_push),
    .i_wdata       ({stbd__dsp__type, stbd__dsp__peId, stbd__dsp__data}),
    .i_pop         (w_pop),
    .o_rdata       (w_head_bits),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_count       (w_count)
  );

  // Bits still waiting for their PE after this edge's handshakes.
  assign w_left = r_valid & ~pe__dsp__ready;

  // NOTE: every variable gets a default first so no path through the case infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid;
    w_err_nxt   = r_err;
    w_load      = 1'b0;
    unique case (r_state)
      ST_IDLE:      w_load = 1'b1;
      ST_ISSUE,
      ST_BCAST: begin
        w_valid_nxt = w_left;
        w_load      = (w_left == '0);
      end
      ST_SYNC_WAIT: if (&pe__sys__thisSynchronized) w_state_nxt = ST_SYNC_REL;
      ST_SYNC_REL:  w_load = 1'b1;
      default:      w_state_nxt = ST_IDLE;
    endcase

    if (w_load) begin
      w_state_nxt = ST_IDLE;
      w_valid_nxt = '0;
      if (!w_empty) begin
        unique case (w_head.typ)
          CMD_UNICAST: begin
            if (w_bad_id) begin
              w_err_nxt = 1'b1;
            end else begin
              w_valid_nxt = NUM_PE'(1) << w_head.pe_id;
              w_state_nxt = ST_ISSUE;
            end
          end
          CMD_BCAST: begin
            w_valid_nxt = '1;
            w_state_nxt = ST_BCAST;
          end
          CMD_SYNC:    w_state_nxt = ST_SYNC_WAIT;
          default:     w_err_nxt   = 1'b1;
        endcase
      end
    end
  end

  assign w_pop       = w_load & ~w_empty;
  assign w_count_nxt = w_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      r_state   <= ST_IDLE;
      r_valid   <= '0;
      r_data    <= '0;
      r_allsync <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_valid   <= w_valid_nxt;
      r_allsync <= (w_state_nxt == ST_SYNC_REL);
      r_busy    <= (w_count_nxt != '0) || (w_state_nxt != ST_IDLE);
      r_err     <= w_err_nxt;
      if (w_pop) r_data <= w_head.data;
    end
  end

  assign dsp__pe__valid           = r_valid;
  assign dsp__pe__data            = r_data;
  assign sys__pe__allSynchronized = r_allsync;
  assign dsp__sys__busy           = r_busy;
  assign dsp__sys__err            = r_err;

endmodule

// File: tb/tb_pe_array_dispatch_cntl.sv
// Self-checking bench: directed scenarios plus random traffic, compared every
// cycle against a transaction-level model of the dispatcher.
module tb_pe_array_dispatch_cntl;
  // A 12-PE array with 4-bit ids leaves ids 12..15 to exercise the bad-id path.
  localparam int NP    = 12;
  localparam int IDW   = 4;
  localparam int DEPTH = 4;

  typedef struct {
    logic [1:0]     t;
    logic [IDW-1:0] id;
    logic [63:0]    d;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid = 1'b0;
  logic [1:0]    typ = '0;
  logic [IDW-1:0] pid = '0;
  logic [63:0]   dat = '0;
  logic [NP-1:0] pe_rdy = '0;
  logic [NP-1:0] this_sync = '0;

  logic          dsp_ready;
  logic [NP-1:0] pe_valid;
  logic [63:0]   pe_data;
  logic          all_sync;
  logic          busy;
  logic          err;

  int  n_vec = 0;
  int  n_mis = 0;
  bit  chk_en = 1'b0;

  // Model state: pending commands, the command currently held, and what it still owes.
  cmd_t          q[$];
  bit            held = 0;
  bit            held_sync = 0;
  bit            released = 0;
  logic [NP-1:0] pending = '0;
  logic [63:0]   m_data = '0;
  bit            m_err = 0;

  always #5 clk = ~clk;

  pe_array_dispatch_cntl #(
    .NUM_PE(NP), .PE_ID_W(IDW), .DATA_W(64), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                       (clk),
    .reset_poweron             (rst),
    .stbd__dsp__valid          (valid),
    .dsp__stbd__ready          (dsp_ready),
    .stbd__dsp__type           (typ),
    .stbd__dsp__peId           (pid),
    .stbd__dsp__data           (dat),
    .dsp__pe__valid            (pe_valid),
    .dsp__pe__data             (pe_data),
    .pe__dsp__ready            (pe_rdy),
    .pe__sys__thisSynchronized (this_sync),
    .sys__pe__allSynchronized  (all_sync),
    .dsp__sys__busy            (busy),
    .dsp__sys__err             (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model, advanced once per rising edge with the inputs the bench applied.
  always @(posedge clk) begin
    bit   fin;
    cmd_t c;
    if (rst) begin
      q.delete();
      held = 0; held_sync = 0; released = 0; pending = '0; m_data = '0; m_err = 0;
    end else begin
      bit accept;
      accept = valid && (q.size() < DEPTH);
      if (!held) fin = 1;
      else if (held_sync) begin
        fin = released;
        if (!released && (&this_sync)) released = 1;
      end else begin
        pending = pending & ~pe_rdy;
        fin = (pending == '0);
      end
      if (fin) begin
        held = 0; held_sync = 0; released = 0; pending = '0;
        if (q.size() > 0) begin
          c = q.pop_front();
          m_data = c.d;
          case (c.t)
            2'd0: if (int'(c.id) < NP) begin held = 1; pending[c.id] = 1'b1; end
                  else m_err = 1;
            2'd1: begin held = 1; pending = '1; end
            2'd2: begin held = 1; held_sync = 1; end
            default: m_err = 1;
          endcase
        end
      end
      if (accept) q.push_back('{t: typ, id: pid, d: dat});
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("stbd_ready", 64'(dsp_ready), 64'(q.size() < DEPTH));
      check("pe_valid",   64'(pe_valid),  64'(pending));
      check("pe_data",    pe_data,        m_data);
      check("all_sync",   64'(all_sync),  64'(held && held_sync && released));
      check("busy",       64'(busy),      64'(held || (q.size() > 0)));
      check("err",        64'(err),       64'(m_err));
    end
  end

  task automatic push(input logic [1:0] t, input int id, input logic [63:0] d);
    valid = 1'b1; typ = t; pid = IDW'(id); dat = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    check("rst_valid", 64'(pe_valid), 64'h0);
    check("rst_ready", 64'(dsp_ready), 64'h1);
    check("rst_busy",  64'(busy), 64'h0);
    check("rst_data",  pe_data, 64'h0);
    rst = 1'b0;
    idle(2);

    // Unicast latency: valid visible one edge after the push edge
    pe_rdy = '0;
    push(2'd0, 5, 64'hA5);
    check("uni_lat_valid", 64'(pe_valid), 64'h0);
    check("uni_lat_busy",  64'(busy), 64'h1);
    @(negedge clk);
    check("uni_valid", 64'(pe_valid), 64'h020);
    check("uni_data",  pe_data, 64'hA5);
    pe_rdy[5] = 1'b1;
    @(negedge clk);
    check("uni_done_valid", 64'(pe_valid), 64'h0);
    check("uni_done_busy",  64'(busy), 64'h0);

    // Back-to-back unicasts, then fill the FIFO behind a stalled PE0
    pe_rdy = '1;
    for (int i = 0; i < 4; i++) push(2'd0, i, 64'h100 + 64'(i));
    idle(4);
    pe_rdy = '0;
    for (int i = 0; i < 5; i++) push(2'd0, i % 4, 64'h200 + 64'(i));
    check("full_ready", 64'(dsp_ready), 64'h0);
    push(2'd0, 3, 64'hDEAD);
    pe_rdy = '1;
    idle(8);

    // Broadcast with PE3 late
    pe_rdy = 12'hFF7;
    push(2'd1, 0, 64'hB0B0);
    @(negedge clk);
    check("bc_all", 64'(pe_valid), 64'hFFF);
    push(2'd0, 7, 64'h77);
    check("bc_hold3", 64'(pe_valid), 64'h008);
    repeat (8) @(negedge clk);
    check("bc_still3", 64'(pe_valid), 64'h008);
    check("bc_data",   pe_data, 64'hB0B0);
    pe_rdy = '1;
    @(negedge clk);
    check("bc_next", 64'(pe_valid), 64'h080);
    idle(3);

    // Barrier with PEs synchronizing one per cycle
    this_sync = '0;
    push(2'd2, 0, 64'h5);
    @(negedge clk);
    for (int i = 0; i < NP; i++) begin
      check("sync_no_pulse", 64'(all_sync), 64'h0);
      this_sync[i] = 1'b1;
      @(negedge clk);
    end
    check("sync_pulse", 64'(all_sync), 64'h1);
    check("sync_no_valid", 64'(pe_valid), 64'h0);
    @(negedge clk);
    check("sync_pulse_end", 64'(all_sync), 64'h0);
    this_sync = '0;
    idle(2);

    // Bad id and reserved type, then a good command
    push(2'd0, NP, 64'hBAD);
    push(2'd3, 0, 64'hBAD3);
    push(2'd0, 2, 64'h22);
    idle(4);
    check("err_sticky", 64'(err), 64'h1);

    // Reset during a half-accepted broadcast with three commands queued
    pe_rdy = 12'h0F0;
    push(2'd1, 0, 64'hCC);
    push(2'd0, 1, 64'h1);
    push(2'd0, 2, 64'h2);
    push(2'd0, 3, 64'h3);
    check("rst_mid_half", 64'(pe_valid), 64'hF0F);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_valid", 64'(pe_valid), 64'h0);
    check("rst_mid_busy",  64'(busy), 64'h0);
    check("rst_mid_err",   64'(err), 64'h0);
    check("rst_mid_ready", 64'(dsp_ready), 64'h1);
    pe_rdy = '1;
    push(2'd0, 9, 64'h99);
    @(negedge clk);
    check("post_rst_uni", 64'(pe_valid), 64'h200);
    idle(3);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      int r;
      rst   = ($urandom_range(0, 299) == 0);
      valid = $urandom_range(0, 1) == 1;
      r     = $urandom_range(0, 15);
      typ   = (r < 7) ? 2'd0 : (r < 11) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      pid   = IDW'($urandom_range(0, 15));
      dat   = {$urandom, $urandom};
      for (int b = 0; b < NP; b++) begin
        pe_rdy[b]    = $urandom_range(0, 3) != 0;
        this_sync[b] = $urandom_range(0, 15) != 0;
      end
      @(negedge clk);
    end
    rst = 1'b0;
    pe_rdy = '1;
    this_sync = '1;
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
